// File: rtl/slc3_mem_pkg.sv
// Shared types for the SLC-3 SRAM arbiter: FSM states, requester ids and
// the strobe decode used by the top-level sequencer.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } mem_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

    localparam int WAIT_CNT_W = 3;

    // Active-low SRAM control strobes; UB/LB are derived from ce.
    typedef struct packed {
        logic ce;
        logic oe;
        logic we;
    } sram_strobe_t;

    function automatic sram_strobe_t strobes_for(input mem_state_t st, input logic is_write);
        sram_strobe_t s;
        s = '{ce: 1'b1, oe: 1'b1, we: 1'b1};
        case (st)
            SETUP: begin
                s.ce = 1'b0;
                s.oe = is_write;
            end
            ACCESS: begin
                s.ce = 1'b0;
                s.oe = is_write;
                s.we = ~is_write;
            end
            RECOVER: s.ce = 1'b0;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/slc3_sram_arbiter_if.sv
// Word-access request channel between one requester (CPU or loader) and
// the SRAM arbiter.
interface slc3_sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin picker: combinational choice, registered last-grant
// pointer that only moves when a grant is actually taken.
module mem_rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_cpu,
    input  logic    req_ld,
    input  logic    grant_en,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t last_reg;
    req_id_t last_next;

    always_comb begin
        grant_valid = req_cpu | req_ld;
        grant_id    = REQ_LD;
        if (req_cpu && req_ld) begin
            grant_id = (last_reg == REQ_LD) ? REQ_CPU : REQ_LD;
        end else if (req_cpu) begin
            grant_id = REQ_CPU;
        end

        last_next = last_reg;
        if (grant_en && grant_valid) begin
            last_next = grant_id;
        end
    end

    // Pointer starts at CPU so a simultaneous first request goes to the loader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= REQ_CPU;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/slc3_sram_arbiter.sv
// SLC-3 external SRAM port owner: arbitrates CPU and loader requests and
// sequences each word access through SETUP / ACCESS(wait states) / RECOVER.
module slc3_sram_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    slc3_sram_arbiter_if.slave cpu,
    slc3_sram_arbiter_if.slave ld,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic              busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    mem_state_t            state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
    req_id_t               id_reg, id_next;
    logic                  we_reg, we_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [DATA_W-1:0]     wdata_reg, wdata_next;
    logic [DATA_W-1:0]     rdata_reg, rdata_next;
    sram_strobe_t          strobe_reg, strobe_next;
    logic                  data_oe_reg, data_oe_next;

    logic    arb_en;
    logic    grant_valid;
    req_id_t grant_id;

    assign arb_en = (state_reg == IDLE);

    mem_rr_arb2 u_arb (
        .clk        (Clk),
        .rst        (Reset),
        .req_cpu    (cpu.req),
        .req_ld     (ld.req),
        .grant_en   (arb_en),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        id_next    = id_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    id_next = grant_id;
                    if (grant_id == REQ_LD) begin
                        we_next    = ld.we;
                        addr_next  = ld.addr;
                        wdata_next = ld.wdata;
                    end else begin
                        we_next    = cpu.we;
                        addr_next  = cpu.addr;
                        wdata_next = cpu.wdata;
                    end
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = WAIT_LOAD;
                state_next = ACCESS;
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    // Final ACCESS edge: read data is captured here.
                    if (!we_reg) begin
                        rdata_next = Data;
                    end
                    state_next = RECOVER;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Pins are registered from the next state so they come out glitch-free.
        strobe_next  = strobes_for(state_next, we_next);
        data_oe_next = we_next && ((state_next == ACCESS) || (state_next == RECOVER));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            id_reg      <= REQ_CPU;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            strobe_reg  <= '{ce: 1'b1, oe: 1'b1, we: 1'b1};
            data_oe_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            id_reg      <= id_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            strobe_reg  <= strobe_next;
            data_oe_reg <= data_oe_next;
        end
    end

    assign ADDR = addr_reg;
    assign CE   = strobe_reg.ce;
    assign UB   = strobe_reg.ce;
    assign LB   = strobe_reg.ce;
    assign OE   = strobe_reg.oe;
    assign WE   = strobe_reg.we;
    assign busy = (state_reg != IDLE);

    assign Data = data_oe_reg ? wdata_reg : {DATA_W{1'bz}};

    assign cpu.ack   = (state_reg == RECOVER) && (id_reg == REQ_CPU);
    assign ld.ack    = (state_reg == RECOVER) && (id_reg == REQ_LD);
    assign cpu.rdata = rdata_reg;
    assign ld.rdata  = rdata_reg;

endmodule

// File: tb/tb_slc3_sram_arbiter.sv
// Bench for slc3_sram_arbiter: SRAM model on the pins, reference memory
// updated at each ack, random and directed transfers, plus a WAIT_STATES=0 build.
module tb_slc3_sram_arbiter;

    localparam int WS = 1;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT with WAIT_STATES=1 ----------------
    slc3_sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) cpu_if ();
    slc3_sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ld_if ();
    wire  [15:0] Data;
    logic [19:0] ADDR;
    logic        CE, UB, LB, OE, WE, busy;

    slc3_sram_arbiter #(.WAIT_STATES(WS), .ADDR_W(20), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .cpu(cpu_if), .ld(ld_if),
        .ADDR(ADDR), .Data(Data), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .busy(busy)
    );

    // ---------------- DUT with WAIT_STATES=0 ----------------
    slc3_sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) cpu0_if ();
    slc3_sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) ld0_if ();
    wire  [15:0] Data0;
    logic [19:0] ADDR0;
    logic        CE0, UB0, LB0, OE0, WE0, busy0;

    slc3_sram_arbiter #(.WAIT_STATES(0), .ADDR_W(20), .DATA_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .cpu(cpu0_if), .ld(ld0_if),
        .ADDR(ADDR0), .Data(Data0), .CE(CE0), .UB(UB0), .LB(LB0), .OE(OE0), .WE(WE0), .busy(busy0)
    );

    assign Data0 = (!CE0 && !OE0 && WE0) ? (ADDR0[15:0] ^ 16'h5A5A) : 16'hzzzz;

    // ---------------- SRAM behavioural model (256 words, aliased) ----------------
    logic [15:0] sram_mem [256];
    bit          sram_wr  [256];
    logic [15:0] sram_rd;

    function automatic logic [15:0] init_word(input logic [7:0] a);
        if (a == 8'h14) return 16'h3001;
        return {a, ~a} ^ 16'h0F0F;
    endfunction

    always_comb sram_rd = sram_wr[ADDR[7:0]] ? sram_mem[ADDR[7:0]] : init_word(ADDR[7:0]);
    assign Data = (!CE && !OE && WE) ? sram_rd : 16'hzzzz;

    always @(posedge Clk) begin
        if (!CE && !WE) begin
            sram_mem[ADDR[7:0]] <= Data;
            sram_wr[ADDR[7:0]]  <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [256];
    logic [15:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit is_ld, input bit rq, input bit we,
                         input logic [19:0] a, input logic [15:0] wd);
        if (is_ld) begin
            ld_if.req = rq; ld_if.we = we; ld_if.addr = a; ld_if.wdata = wd;
        end else begin
            cpu_if.req = rq; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = wd;
        end
    endtask

    // Score a completed transfer against the reference memory.
    task automatic score(input bit is_ld, input bit we, input logic [19:0] a, input logic [15:0] wd);
        logic [15:0] mine, other;
        mine  = is_ld ? ld_if.rdata : cpu_if.rdata;
        other = is_ld ? cpu_if.rdata : ld_if.rdata;
        if (we) begin
            chk("wr_hold_data", Data, wd);
            chk("rdata_kept", mine, last_rd);
            ref_mem[a[7:0]] = wd;
        end else begin
            chk("rdata", mine, ref_mem[a[7:0]]);
            chk("rdata_shared", other, ref_mem[a[7:0]]);
            last_rd = ref_mem[a[7:0]];
        end
        $display("xfer %s %s addr=%05h data=%04h", is_ld ? "LD " : "CPU", we ? "W" : "R", a,
                 we ? wd : mine);
    endtask

    // First posedge after entry is the accepting edge.
    task automatic wait_ack(input bit is_ld, input bit we, input logic [19:0] a,
                            input logic [15:0] wd, input bit garble);
        int oe_lo, we_lo, busy_n, other;
        bit got;
        oe_lo = 0; we_lo = 0; busy_n = 0; other = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (i == 0) chk("addr_pin", ADDR, a);
            if (!OE) oe_lo++;
            if (!WE) begin
                we_lo++;
                chk("wr_bus", Data, wd);
            end
            if (busy) busy_n++;
            if (is_ld ? cpu_if.ack : ld_if.ack) other++;
            if (garble && i == 0) drive(is_ld, 1'b0, ~we, 20'($urandom), 16'($urandom));
            if (is_ld ? ld_if.ack : cpu_if.ack) begin
                got = 1;
                chk("ack_latency", i, 2 + WS);
                score(is_ld, we, a, wd);
                drive(is_ld, 1'b0, we, a, wd);
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge Clk);
        @(negedge Clk);
        chk("idle_after", busy, 0);
        chk("oe_low_cycles", oe_lo, we ? 0 : 2 + WS);
        chk("we_low_cycles", we_lo, we ? 1 + WS : 0);
        chk("busy_cycles", busy_n, 3 + WS);
        chk("other_ack", other, 0);
    endtask

    task automatic xfer(input bit is_ld, input bit we, input logic [19:0] a,
                        input logic [15:0] wd, input bit garble);
        @(negedge Clk);
        drive(is_ld, 1'b1, we, a, wd);
        wait_ack(is_ld, we, a, wd, garble);
    endtask

    // Pin invariants, every cycle out of reset.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("oe_we_excl", {31'd0, OE | WE}, 1);
            chk("ack_excl", {31'd0, cpu_if.ack & ld_if.ack}, 0);
            chk("ub_lb_track", {30'd0, UB, LB}, {30'd0, CE, CE});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pwe [2];
        logic [19:0] pa  [2];
        logic [15:0] pwd [2];
        int          acks, last_t, exp_id, id;
        bit          r_ld, r_we, r_gb;
        logic [19:0] r_a;
        int          oe0, busy0_n;
        bit          got0;

        Reset = 1'b1;
        last_rd = '0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        cpu0_if.req = 1'b0; cpu0_if.we = 1'b0; cpu0_if.addr = '0; cpu0_if.wdata = '0;
        ld0_if.req  = 1'b0; ld0_if.we  = 1'b0; ld0_if.addr  = '0; ld0_if.wdata  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Reset state
        chk("rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {30'd0, cpu_if.ack, ld_if.ack}, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_rdata", cpu_if.rdata, 0);

        // Directed reads/writes
        xfer(1'b0, 1'b0, 20'h00014, 16'h0000, 1'b0);
        chk("dir_read_3001", cpu_if.rdata, 16'h3001);
        xfer(1'b1, 1'b1, 20'h00031, 16'hBEEF, 1'b0);
        xfer(1'b0, 1'b0, 20'h00031, 16'h0000, 1'b0);
        chk("dir_read_beef", cpu_if.rdata, 16'hBEEF);

        // Random single transfers, some with req dropped and fields scrambled mid-flight
        for (int n = 0; n < 16; n++) begin
            r_ld = 1'($urandom_range(0, 1));
            r_we = 1'($urandom_range(0, 1));
            r_gb = 1'($urandom_range(0, 1));
            r_a  = {12'($urandom), 8'($urandom_range(0, 7))};
            xfer(r_ld, r_we, r_a, 16'($urandom), r_gb);
        end

        // Both requesters held from reset: strict alternation starting with loader
        @(negedge Clk);
        Reset = 1'b1;
        last_rd = '0;
        for (int r = 0; r < 2; r++) begin
            pwe[r] = 1'($urandom_range(0, 1));
            pa[r]  = {12'($urandom), 8'($urandom_range(0, 7))};
            pwd[r] = 16'($urandom);
            drive(r[0], 1'b1, pwe[r], pa[r], pwd[r]);
        end
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        acks = 0; last_t = 0; exp_id = 1;
        for (int t = 0; t < 100 && acks < 8; t++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (cpu_if.ack || ld_if.ack) begin
                id = ld_if.ack ? 1 : 0;
                chk("rr_order", id, exp_id);
                if (acks == 0) chk("rr_first_latency", t, 2 + WS);
                else           chk("rr_gap", t - last_t, 4 + WS);
                score(id[0], pwe[id], pa[id], pwd[id]);
                acks++;
                last_t = t;
                exp_id = 1 - id;
                if (acks < 8) begin
                    pwe[id] = 1'($urandom_range(0, 1));
                    pa[id]  = {12'($urandom), 8'($urandom_range(0, 7))};
                    pwd[id] = 16'($urandom);
                    drive(id[0], 1'b1, pwe[id], pa[id], pwd[id]);
                end else begin
                    drive(1'b0, 1'b0, 1'b0, '0, '0);
                    drive(1'b1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        chk("rr_ack_count", acks, 8);
        repeat (3) @(negedge Clk);
        chk("rr_idle", busy, 0);

        // Reset pulsed during a loader write ACCESS
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b1, 20'h00077, 16'h1357);
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        chk("abort_pre_we", WE, 0);
        #1 Reset = 1'b1;
        last_rd = '0;
        #1;
        chk("abort_strobes", {29'd0, CE, OE, WE}, 32'h7);
        chk("abort_busy", busy, 0);
        chk("abort_ack", ld_if.ack, 0);
        repeat (2) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("abort_no_ack", ld_if.ack, 0);
        end
        Reset = 1'b0;
        wait_ack(1'b1, 1'b1, 20'h00077, 16'h1357, 1'b0);
        xfer(1'b0, 1'b0, 20'h00077, 16'h0000, 1'b0);
        chk("abort_readback", cpu_if.rdata, 16'h1357);

        // WAIT_STATES=0 build: CPU read
        @(negedge Clk);
        cpu0_if.req = 1'b1; cpu0_if.we = 1'b0; cpu0_if.addr = 20'h0ABCD;
        oe0 = 0; busy0_n = 0; got0 = 0;
        for (int i = 0; i < 12 && !got0; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (!OE0) oe0++;
            if (busy0) busy0_n++;
            if (cpu0_if.ack) begin
                got0 = 1;
                chk("ws0_latency", i, 2);
                chk("ws0_rdata", cpu0_if.rdata, 16'hABCD ^ 16'h5A5A);
                $display("xfer WS0 CPU R addr=%05h data=%04h", cpu0_if.addr, cpu0_if.rdata);
                cpu0_if.req = 1'b0;
            end
        end
        if (!got0) chk("ws0_ack_timeout", 0, 1);
        @(posedge Clk);
        @(negedge Clk);
        chk("ws0_oe_cycles", oe0, 2);
        chk("ws0_busy_cycles", busy0_n, 3);
        chk("ws0_idle", busy0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
